// File: rtl/add_share_arb.sv
// Round-robin arbiter sharing one WIDTH-bit adder between requesters A and B.
// The registered {carry, sum} is returned with a requester tag over a valid/ready channel.
module add_share_arb #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             a_valid,
  output logic             a_ready,
  input  logic [WIDTH-1:0] a_op0,
  input  logic [WIDTH-1:0] a_op1,
  input  logic             a_cin,
  input  logic             b_valid,
  output logic             b_ready,
  input  logic [WIDTH-1:0] b_op0,
  input  logic [WIDTH-1:0] b_op1,
  input  logic             b_cin,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [WIDTH:0]   res_sum,
  output logic             res_id
);

  typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;

  state_t           state, state_nxt;
  logic             ptr;
  logic             space;
  logic             accept;
  logic             gid;
  logic [WIDTH-1:0] sel_op0, sel_op1;
  logic             sel_cin;
  logic [WIDTH:0]   sum;

  assign res_valid = (state == FULL);
  assign space     = !res_valid || res_ready;

  // A tie goes to the pointer; a lone requester wins regardless of the pointer.
  assign a_ready = !rst && space && a_valid && (!b_valid || !ptr);
  assign b_ready = !rst && space && b_valid && (!a_valid ||  ptr);
  assign accept  = a_ready || b_ready;
  assign gid     = b_ready;

  // Single shared adder, operands muxed by the grant.
  assign sel_op0 = gid ? b_op0 : a_op0;
  assign sel_op1 = gid ? b_op1 : a_op1;
  assign sel_cin = gid ? b_cin : a_cin;
  assign sum     = {1'b0, sel_op0} + {1'b0, sel_op1} + {{WIDTH{1'b0}}, sel_cin};

  always_comb begin
    state_nxt = state;
    case (state)
      EMPTY:   if (accept) state_nxt = FULL;
      FULL:    if (res_ready && !accept) state_nxt = EMPTY;
      default: state_nxt = EMPTY;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= EMPTY;
      ptr     <= 1'b0;
      res_sum <= '0;
      res_id  <= 1'b0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        res_sum <= sum;
        res_id  <= gid;
        ptr     <= ~gid;
      end
    end
  end

endmodule
